// File: rtl/fifo_pkg.sv
// Shared helpers for the level-tracking UART FIFO: level width and
// parameter range checks used at elaboration.
package fifo_pkg;

  function automatic int lvl_w(input int w);
    return w + 1;
  endfunction

  function automatic bit af_ok(input int w, input int af);
    return (af >= 1) && (af <= (1 << w));
  endfunction

  function automatic bit ae_ok(input int w, input int ae);
    return (ae >= 0) && (ae <= (1 << w) - 1);
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Storage array for the FIFO: synchronous write port, asynchronous
// read port. Contents are not reset.
module fifo_regfile #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic [B-1:0] wdata,
  input  logic [W-1:0] raddr,
  output logic [B-1:0] rdata
);

  logic [B-1:0] mem_q [2**W];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_uart_lvl.sv
// Level-tracking FIFO with thresholds, flush and sticky error flags.
// Error flags are built only when FIFO_ERR_FLAGS_EN is defined.
module fifo_uart_lvl import fifo_pkg::*; #(
  parameter int B      = 8,
  parameter int W      = 4,
  parameter int AF_LVL = 2**W - 2,
  parameter int AE_LVL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            wr,
  input  logic [B-1:0]    w_data,
  input  logic            rd,
  output logic [B-1:0]    r_data,
  output logic            empty,
  output logic            full,
  output logic            almost_empty,
  output logic            almost_full,
  output logic [W:0]      level,
  output logic            overflow,
  output logic            underflow,
  input  logic            clr_err
);

  localparam int LW = lvl_w(W);
  localparam logic [LW-1:0] FULL_L = LW'(2**W);
  localparam logic [LW-1:0] AF_L   = LW'(AF_LVL);
  localparam logic [LW-1:0] AE_L   = LW'(AE_LVL);

  if (!af_ok(W, AF_LVL)) begin : g_af_bad
    $error("fifo_uart_lvl: AF_LVL out of range");
  end
  if (!ae_ok(W, AE_LVL)) begin : g_ae_bad
    $error("fifo_uart_lvl: AE_LVL out of range");
  end

  logic [W-1:0]  w_ptr_q, w_ptr_d;
  logic [W-1:0]  r_ptr_q, r_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ae_q, ae_d;
  logic          af_q, af_d;
  logic          wr_en, rd_en, we;

  // A full FIFO still accepts a write when a read frees a slot this cycle.
  always_comb begin
    wr_en   = wr & (~full_q | rd);
    rd_en   = rd & ~empty_q;
    we      = wr_en & ~flush;
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    level_d = level_q;
    if (flush) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      level_d = '0;
    end else begin
      if (wr_en) w_ptr_d = w_ptr_q + W'(1);
      if (rd_en) r_ptr_d = r_ptr_q + W'(1);
      level_d = level_q + LW'(wr_en) - LW'(rd_en);
    end
    empty_d = (level_d == '0);
    full_d  = (level_d == FULL_L);
    ae_d    = (level_d <= AE_L);
    af_d    = (level_d >= AF_L);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      level_q <= level_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
    end
  end

  fifo_regfile #(.B(B), .W(W)) u_regfile (
    .clk   (clk),
    .we    (we),
    .waddr (w_ptr_q),
    .wdata (w_data),
    .raddr (r_ptr_q),
    .rdata (r_data)
  );

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign level        = level_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // A new error wins over clr_err in the same cycle.
  always_comb begin
    ovf_d = (ovf_q & ~clr_err) | (~flush & wr & full_q & ~rd);
    udf_d = (udf_q & ~clr_err) | (~flush & rd & empty_q & ~wr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  logic unused_clr;
  assign unused_clr = clr_err;
  assign overflow   = 1'b0;
  assign underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_uart_lvl.sv
// Self-checking bench for fifo_uart_lvl: queue model checked every
// cycle plus directed literal expectations.
module tb_fifo_uart_lvl;

  localparam int B = 8;
  localparam int W = 4;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 1;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  logic flush, wr, rd, clr_err;
  logic [B-1:0] w_data;
  logic [B-1:0] r_data;
  logic empty, full, almost_empty, almost_full;
  logic [W:0] level;
  logic overflow, underflow;

  int checks = 0;
  int errors = 0;

  fifo_uart_lvl #(.B(B), .W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .wr           (wr),
    .w_data       (w_data),
    .rd           (rd),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: contents as a queue, sticky error bits.
  logic [B-1:0] mq[$];
  bit m_ovf, m_udf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      bit do_wr, do_rd, new_ovf, new_udf;
      new_ovf = 1'b0;
      new_udf = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        do_rd = rd && (mq.size() > 0);
        do_wr = wr && ((mq.size() < DEPTH) || rd);
        new_ovf = wr && !rd && (mq.size() == DEPTH);
        new_udf = rd && !wr && (mq.size() == 0);
        if (do_rd) void'(mq.pop_front());
        if (do_wr) mq.push_back(w_data);
      end
      if (ERR_EN) begin
        if (clr_err) begin
          m_ovf = 1'b0;
          m_udf = 1'b0;
        end
        if (new_ovf) m_ovf = 1'b1;
        if (new_udf) m_udf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    int n;
    n = mq.size();
    chk("m_level", 32'(level), n);
    chk("m_empty", 32'(empty), 32'(n == 0));
    chk("m_full", 32'(full), 32'(n == DEPTH));
    chk("m_aempty", 32'(almost_empty), 32'(n <= AE));
    chk("m_afull", 32'(almost_full), 32'(n >= AF));
    chk("m_ovf", 32'(overflow), 32'(m_ovf));
    chk("m_udf", 32'(underflow), 32'(m_udf));
    if (n > 0) chk("m_rdata", 32'(r_data), 32'(mq[0]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    w_data = '0;
    #12;
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);
    step();
    reset = 1'b0;

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; w_data = 8'(i);
      step();
      if (i == 0) begin
        chk("w1_empty", 32'(empty), 0);
        chk("w1_rdata", 32'(r_data), 8'h00);
      end
      if (i == 12) chk("w13_af", 32'(almost_full), 0);
      if (i == 13) chk("w14_af", 32'(almost_full), 1);
    end
    wr = 1'b0;
    chk("w16_full", 32'(full), 1);
    chk("w16_level", 32'(level), 16);

    // Overflow attempt
    wr = 1'b1; w_data = 8'hAA;
    step();
    wr = 1'b0;
    chk("ovf_level", 32'(level), 16);
    chk("ovf_flag", 32'(overflow), 32'(ERR_EN));
    for (int i = 0; i < 16; i++) begin
      chk("drain1", 32'(r_data), i);
      rd = 1'b1;
      step();
    end
    rd = 1'b0;
    chk("drain1_empty", 32'(empty), 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);

    // wr & rd on empty
    wr = 1'b1; rd = 1'b1; w_data = 8'h55;
    step();
    wr = 1'b0; rd = 1'b0;
    chk("wre_level", 32'(level), 1);
    chk("wre_rdata", 32'(r_data), 8'h55);
    chk("wre_udf", 32'(underflow), 0);
    rd = 1'b1;
    step();
    step();
    chk("udf_set", 32'(underflow), 32'(ERR_EN));
    clr_err = 1'b1;
    step();
    rd = 1'b0;
    chk("udf_setwins", 32'(underflow), 32'(ERR_EN));
    step();
    clr_err = 1'b0;
    chk("udf_clr", 32'(underflow), 0);

    // Full, simultaneous wr/rd across pointer wrap
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; w_data = 8'(8'h10 + i);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      chk("wrap_rd", 32'(r_data), (i < 16) ? (8'h10 + i) : (8'h80 + i - 16));
      wr = 1'b1; rd = 1'b1; w_data = 8'(8'h80 + i);
      step();
      chk("wrap_level", 32'(level), 16);
      chk("wrap_full", 32'(full), 1);
    end
    wr = 1'b0;
    for (int i = 4; i < 20; i++) begin
      chk("drain2", 32'(r_data), 8'h80 + i);
      step();
    end
    rd = 1'b0;
    chk("drain2_empty", 32'(empty), 1);

    // Flush beats write
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; w_data = 8'(8'h20 + i);
      step();
    end
    chk("pre_flush_lvl", 32'(level), 5);
    flush = 1'b1; w_data = 8'hEE;
    step();
    flush = 1'b0; wr = 1'b0;
    chk("fl_level", 32'(level), 0);
    chk("fl_empty", 32'(empty), 1);
    chk("fl_ae", 32'(almost_empty), 1);
    wr = 1'b1; w_data = 8'h33;
    step();
    wr = 1'b0;
    chk("fl_next", 32'(r_data), 8'h33);
    chk("fl_next_lvl", 32'(level), 1);
    rd = 1'b1;
    step();
    rd = 1'b0;

    // Asynchronous reset mid-burst
    for (int i = 0; i < 7; i++) begin
      wr = 1'b1; w_data = 8'(8'h40 + i);
      step();
    end
    chk("pre_rst_lvl", 32'(level), 7);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_level", 32'(level), 0);
    chk("ar_empty", 32'(empty), 1);
    chk("ar_full", 32'(full), 0);
    chk("ar_ae", 32'(almost_empty), 1);
    chk("ar_af", 32'(almost_full), 0);
    wr = 1'b0;
    step();
    reset = 1'b0;
    wr = 1'b1; w_data = 8'h99;
    step();
    wr = 1'b0;
    chk("ar_next", 32'(r_data), 8'h99);
    chk("ar_next_lvl", 32'(level), 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
